wb_arbiter_stage: RTL and testbench

Registered, parametrised write-back stage for the MIPS pipeline. It captures the MEM-stage result, selects among ALU, memory-load and link values, and performs little-endian sub-word load extraction. It drives the register-file write port, which it shares with an auxiliary multi-cycle writer (divider/coprocessor) through a req/ack handshake with starvation protection. The block sits between the MEM stage and the register file and replaces the purely combinational write-back mux.

---
 rtl/wb_arbiter_stage.sv | 123 ++++++++++++
 tb/tb_wb_arbiter_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_stage.sv
// Registered write-back stage: selects ALU/MEM/LINK data and shares the register-file write port with an aux writer.
// Optional sub-word load extraction is built only when WB_LOAD_EXT_EN is defined.
module wb_arbiter_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int STARVE_LIMIT   = 4,
  localparam int LANE_W        = $clog2(DATA_WIDTH / 8)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic [1:0]                in_sel,
  input  logic [1:0]                in_ld_size,
  input  logic                      in_ld_unsigned,
  input  logic [LANE_W-1:0]         in_addr_lo,
  input  logic [DATA_WIDTH-1:0]     in_alu,
  input  logic [DATA_WIDTH-1:0]     in_mem,
  input  logic [DATA_WIDTH-1:0]     in_link,
  input  logic                      aux_req,
  input  logic [REG_ADDR_WIDTH-1:0] aux_addr,
  input  logic [DATA_WIDTH-1:0]     aux_data,
  output logic                      aux_ack,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata
);

  logic                      rf_we_q, rf_we_d;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0]     rf_wdata_q, rf_wdata_d;
  logic                      aux_ack_q, aux_ack_d;
  logic [3:0]                starve_q, starve_d;

  logic                  starve, pipe_wr, aux_pend, grant_aux;
  logic [DATA_WIDTH-1:0] mem_val, pipe_data;

`ifdef WB_LOAD_EXT_EN
  logic [DATA_WIDTH-1:0] byte_sh, half_sh;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;

  always_comb begin
    byte_sh = in_mem >> {in_addr_lo, 3'b000};
    half_sh = in_mem >> {in_addr_lo >> 1, 4'b0000};
    byte_v  = byte_sh[7:0];
    half_v  = half_sh[15:0];
    case (in_ld_size)
      2'b00:   mem_val = {{(DATA_WIDTH-8){~in_ld_unsigned & byte_v[7]}}, byte_v};
      2'b01:   mem_val = {{(DATA_WIDTH-16){~in_ld_unsigned & half_v[15]}}, half_v};
      default: mem_val = in_mem;
    endcase
  end
`else
  logic unused_ld_fields;
  assign unused_ld_fields = ^{in_ld_size, in_ld_unsigned, in_addr_lo};
  assign mem_val = in_mem;
`endif

  always_comb begin
    case (in_sel)
      2'b01:   pipe_data = mem_val;
      2'b10:   pipe_data = in_link;
      default: pipe_data = in_alu;
    endcase
  end

  // Starvation throttles the pipeline for one cycle so the aux write can take the port.
  assign starve    = (starve_q == 4'(STARVE_LIMIT));
  assign in_ready  = ~starve;
  assign pipe_wr   = in_valid & in_ready & in_reg_write;
  assign aux_pend  = aux_req & ~aux_ack_q;
  assign grant_aux = aux_pend & (starve | ~pipe_wr);

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    aux_ack_d  = grant_aux;
    if (grant_aux) begin
      rf_we_d    = |aux_addr;
      rf_waddr_d = aux_addr;
      rf_wdata_d = aux_data;
    end else if (pipe_wr) begin
      rf_we_d    = |in_rd;
      rf_waddr_d = in_rd;
      rf_wdata_d = pipe_data;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!aux_req || grant_aux) begin
      starve_d = 4'd0;
    end else if (aux_pend && !starve) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      aux_ack_q  <= 1'b0;
      starve_q   <= 4'd0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      aux_ack_q  <= aux_ack_d;
      starve_q   <= starve_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign aux_ack  = aux_ack_q;

endmodule

// File: tb/tb_wb_arbiter_stage.sv
// Directed bench for wb_arbiter_stage: vector table for data selection plus arbitration sequences.
module tb_wb_arbiter_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_reg_write, in_ld_unsigned;
  logic [4:0]  in_rd, aux_addr, rf_waddr;
  logic [1:0]  in_sel, in_ld_size, in_addr_lo;
  logic [31:0] in_alu, in_mem, in_link, aux_data, rf_wdata;
  logic        aux_req, aux_ack, rf_we;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_arbiter_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg_write(in_reg_write),
    .in_rd(in_rd), .in_sel(in_sel), .in_ld_size(in_ld_size),
    .in_ld_unsigned(in_ld_unsigned), .in_addr_lo(in_addr_lo),
    .in_alu(in_alu), .in_mem(in_mem), .in_link(in_link),
    .aux_req(aux_req), .aux_addr(aux_addr), .aux_data(aux_data), .aux_ack(aux_ack),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lo;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] link;
    logic        exp_we;
    logic [31:0] exp_ext;
    logic [31:0] exp_raw;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_reg_write = 1'b0; in_rd = '0; in_sel = 2'b00;
    in_ld_size = 2'b00; in_ld_unsigned = 1'b0; in_addr_lo = 2'b00;
    in_alu = '0; in_mem = '0; in_link = '0;
    aux_req = 1'b0; aux_addr = '0; aux_data = '0;
  endtask

  initial begin
    logic [31:0] exp_d;
    int k;
    vecs[0]  = '{2'b00, 2'b00, 1'b0, 2'd0, 5'd3,  1'b1, 32'h12345678, 32'h0,        32'h0,        1'b1, 32'h12345678, 32'h12345678};
    vecs[1]  = '{2'b01, 2'b00, 1'b0, 2'd3, 5'd4,  1'b1, 32'h0,        32'h80FF7F01, 32'h0,        1'b1, 32'hFFFFFF80, 32'h80FF7F01};
    vecs[2]  = '{2'b01, 2'b00, 1'b1, 2'd1, 5'd5,  1'b1, 32'h0,        32'h80FF7F01, 32'h0,        1'b1, 32'h0000007F, 32'h80FF7F01};
    vecs[3]  = '{2'b01, 2'b01, 1'b0, 2'd2, 5'd6,  1'b1, 32'h0,        32'h80FF7F01, 32'h0,        1'b1, 32'hFFFF80FF, 32'h80FF7F01};
    vecs[4]  = '{2'b01, 2'b01, 1'b1, 2'd0, 5'd7,  1'b1, 32'h0,        32'h80FF7F01, 32'h0,        1'b1, 32'h00007F01, 32'h80FF7F01};
    vecs[5]  = '{2'b01, 2'b10, 1'b0, 2'd1, 5'd8,  1'b1, 32'h0,        32'h80FF7F01, 32'h0,        1'b1, 32'h80FF7F01, 32'h80FF7F01};
    vecs[6]  = '{2'b10, 2'b00, 1'b0, 2'd0, 5'd31, 1'b1, 32'h1,        32'h2,        32'hBFC00010, 1'b1, 32'hBFC00010, 32'hBFC00010};
    vecs[7]  = '{2'b11, 2'b00, 1'b0, 2'd0, 5'd9,  1'b1, 32'hDEADBEEF, 32'h11111111, 32'h0,        1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[8]  = '{2'b00, 2'b00, 1'b0, 2'd0, 5'd0,  1'b1, 32'hCAFEF00D, 32'h0,        32'h0,        1'b0, 32'h0,        32'h0};
    vecs[9]  = '{2'b00, 2'b00, 1'b0, 2'd0, 5'd10, 1'b0, 32'h55555555, 32'h0,        32'h0,        1'b0, 32'h0,        32'h0};
    vecs[10] = '{2'b01, 2'b00, 1'b0, 2'd0, 5'd11, 1'b1, 32'h0,        32'h000000FE, 32'h0,        1'b1, 32'hFFFFFFFE, 32'h000000FE};
    vecs[11] = '{2'b01, 2'b01, 1'b0, 2'd3, 5'd12, 1'b1, 32'h0,        32'h7FFF8000, 32'h0,        1'b1, 32'h00007FFF, 32'h7FFF8000};

    idle_inputs();
    rst = 1'b1;
    #12;
    chk("reset_rf_we", {31'b0, rf_we}, 32'd0);
    chk("reset_rf_waddr", {27'b0, rf_waddr}, 32'd0);
    chk("reset_rf_wdata", rf_wdata, 32'd0);
    chk("reset_aux_ack", {31'b0, aux_ack}, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Single-beat pipeline writes through every source and load shape.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sel = vecs[i].sel; in_ld_size = vecs[i].size;
      in_ld_unsigned = vecs[i].uns; in_addr_lo = vecs[i].lo; in_rd = vecs[i].rd;
      in_reg_write = vecs[i].rw; in_alu = vecs[i].alu; in_mem = vecs[i].mem; in_link = vecs[i].link;
      tick();
`ifdef WB_LOAD_EXT_EN
      exp_d = vecs[i].exp_ext;
`else
      exp_d = vecs[i].exp_raw;
`endif
      chk($sformatf("vec%0d_rf_we", i), {31'b0, rf_we}, {31'b0, vecs[i].exp_we});
      chk($sformatf("vec%0d_aux_ack", i), {31'b0, aux_ack}, 32'd0);
      if (vecs[i].exp_we) begin
        chk($sformatf("vec%0d_rf_waddr", i), {27'b0, rf_waddr}, {27'b0, vecs[i].rd});
        chk($sformatf("vec%0d_rf_wdata", i), rf_wdata, exp_d);
      end
    end

    // Aux write to $0: acknowledged but not written.
    @(negedge clk);
    idle_inputs();
    aux_req = 1'b1; aux_addr = 5'd0; aux_data = 32'h55;
    tick();
    chk("aux0_ack", {31'b0, aux_ack}, 32'd1);
    chk("aux0_rf_we", {31'b0, rf_we}, 32'd0);
    @(negedge clk);
    aux_req = 1'b0;
    tick();
    chk("aux0_ack_drop", {31'b0, aux_ack}, 32'd0);

    // Starvation under back-to-back pipeline writes.
    @(negedge clk);
    aux_req = 1'b1; aux_addr = 5'd7; aux_data = 32'hA5;
    k = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 6) aux_req = 1'b0;
      in_valid = 1'b1; in_reg_write = 1'b1; in_sel = 2'b00;
      in_rd = 5'(16 + k); in_alu = 32'h100 + k;
      #1;
      chk($sformatf("starve_c%0d_in_ready", c), {31'b0, in_ready}, (c == 5) ? 32'd0 : 32'd1);
      tick();
      if (c == 5) begin
        chk("starve_aux_we", {31'b0, rf_we}, 32'd1);
        chk("starve_aux_waddr", {27'b0, rf_waddr}, 32'd7);
        chk("starve_aux_wdata", rf_wdata, 32'hA5);
        chk("starve_aux_ack", {31'b0, aux_ack}, 32'd1);
      end else begin
        chk($sformatf("starve_c%0d_we", c), {31'b0, rf_we}, 32'd1);
        chk($sformatf("starve_c%0d_waddr", c), {27'b0, rf_waddr}, 32'(16 + k));
        chk($sformatf("starve_c%0d_wdata", c), rf_wdata, 32'h100 + k);
        chk($sformatf("starve_c%0d_ack", c), {31'b0, aux_ack}, 32'd0);
        k++;
      end
    end
    chk("starve_beats_written", k, 32'd5);

    // Aux granted during a bubble; held request in the ack cycle is not re-granted.
    @(negedge clk);
    idle_inputs();
    in_valid = 1'b1; in_reg_write = 1'b0; in_rd = 5'd20; in_alu = 32'h999;
    aux_req = 1'b1; aux_addr = 5'd12; aux_data = 32'h77;
    tick();
    chk("bubble_aux_we", {31'b0, rf_we}, 32'd1);
    chk("bubble_aux_waddr", {27'b0, rf_waddr}, 32'd12);
    chk("bubble_aux_wdata", rf_wdata, 32'h77);
    chk("bubble_aux_ack", {31'b0, aux_ack}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    chk("held_req_no_rewrite_we", {31'b0, rf_we}, 32'd0);
    chk("held_req_no_reack", {31'b0, aux_ack}, 32'd0);

    // Reset while an aux grant is in flight; request serviced afresh after release.
    @(negedge clk);
    idle_inputs();
    in_valid = 1'b1; in_reg_write = 1'b1; in_rd = 5'd13; in_alu = 32'h1313;
    aux_req = 1'b1; aux_addr = 5'd14; aux_data = 32'h99;
    tick();
    chk("rstseq_pipe_waddr", {27'b0, rf_waddr}, 32'd13);
    chk("rstseq_pipe_ack", {31'b0, aux_ack}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    chk("rstseq_aux_ack", {31'b0, aux_ack}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rstseq_rf_we_cleared", {31'b0, rf_we}, 32'd0);
    chk("rstseq_ack_cleared", {31'b0, aux_ack}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rstseq_retry_we", {31'b0, rf_we}, 32'd1);
    chk("rstseq_retry_waddr", {27'b0, rf_waddr}, 32'd14);
    chk("rstseq_retry_wdata", rf_wdata, 32'h99);
    chk("rstseq_retry_ack", {31'b0, aux_ack}, 32'd1);
    @(negedge clk);
    aux_req = 1'b0;
    tick();
    chk("rstseq_idle_we", {31'b0, rf_we}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
